// File: rtl/ram_blk_pkg.sv
// Shared types and helpers for the pipelined block RAM.
// Parity lanes exist only when RAM_BLK_PARITY_EN is defined.
package ram_blk_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned COLL_READ_OLD   = 0;
  localparam int unsigned COLL_WRITE_THRU = 1;

  function automatic int unsigned byte_lanes(input int unsigned data_bits);
    return data_bits / 8;
  endfunction

  // Even parity: stored bit makes the 9-bit lane have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_blk_init_fsm.sv
// Post-reset zero-initialisation sequencer: walks every address once, then
// parks in RUN until the next reset.
module ram_blk_init_fsm
  import ram_blk_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 aresetn,
  output logic                 init_we,
  output logic [ADDR_BITS-1:0] init_addr,
  output logic                 init_done
);

  state_t state;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_INIT;
      init_addr <= '0;
      init_we   <= 1'b1;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_addr == '1) begin
            state     <= ST_RUN;
            init_we   <= 1'b0;
            init_done <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_blk_pipe.sv
// Simple dual-port RAM with byte enables, registered read pipeline (1 or 2
// cycles), defined collision behaviour and post-reset zero fill.
// Optional per-byte even parity: define RAM_BLK_PARITY_EN.
module ram_blk_pipe
  import ram_blk_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 5,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned COLLISION_MODE = 0
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [DATA_BITS/8-1:0] wr_be,
  input  logic                   rd_en,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  output logic [DATA_BITS/8-1:0] rd_perr,
  output logic                   init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned NB    = byte_lanes(DATA_BITS);

  logic                 init_we;
  logic                 init_run;
  logic [ADDR_BITS-1:0] init_addr;

  ram_blk_init_fsm #(
    .ADDR_BITS(ADDR_BITS)
  ) u_init (
    .clk      (clk),
    .aresetn  (aresetn),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_done(init_run)
  );

  assign init_done = init_run;

  // User ports are only honoured once the zero fill is complete.
  logic user_we;
  logic user_re;
  assign user_we = wr_en & init_run;
  assign user_re = rd_en & init_run;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_data;
  logic [NB-1:0]        mem_be;

  assign mem_we   = init_we | user_we;
  assign mem_addr = init_we ? init_addr : wr_addr;
  assign mem_data = init_we ? '0 : wr_data;
  assign mem_be   = init_we ? '1 : wr_be;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

`ifdef RAM_BLK_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;

  always_comb begin
    wr_par = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wr_par[i] = byte_parity(mem_data[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) par_mem[mem_addr][i] <= wr_par[i];
      end
    end
  end
`endif

  // Read port: the array is read before this edge's write lands, so the
  // write-through case must splice enabled write lanes in explicitly.
  logic                 coll;
  logic [DATA_BITS-1:0] rd_word;
  logic [NB-1:0]        rd_chk;

  assign coll = user_we && (wr_addr == rd_addr) &&
                (COLLISION_MODE == COLL_WRITE_THRU);

`ifdef RAM_BLK_PARITY_EN
  logic [NB-1:0] rd_par;

  always_comb begin
    rd_word = mem[rd_addr];
    rd_par  = par_mem[rd_addr];
    rd_chk  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (coll && wr_be[i]) begin
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
        rd_par[i]         = wr_par[i];
      end
      rd_chk[i] = byte_parity(rd_word[8*i +: 8]) ^ rd_par[i];
    end
  end
`else
  always_comb begin
    rd_word = mem[rd_addr];
    rd_chk  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (coll && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end
`endif

  logic                 s1_valid;
  logic [DATA_BITS-1:0] s1_data;
  logic [NB-1:0]        s1_perr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_perr  <= '0;
    end else begin
      s1_valid <= user_re;
      if (user_re) s1_data <= rd_word;
      s1_perr  <= user_re ? rd_chk : '0;
    end
  end

  generate
    if ((DATA_BITS % 8) != 0 || DATA_BITS == 0) begin : g_bad_width
      $error("ram_blk_pipe: DATA_BITS must be a non-zero multiple of 8");
    end

    if (RD_LATENCY == 1) begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
      assign rd_perr  = s1_perr;
    end else if (RD_LATENCY == 2) begin : g_lat2
      logic                 s2_valid;
      logic [DATA_BITS-1:0] s2_data;
      logic [NB-1:0]        s2_perr;

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_perr  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
          s2_perr  <= s1_valid ? s1_perr : '0;
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
      assign rd_perr  = s2_perr;
    end else begin : g_bad_lat
      $error("ram_blk_pipe: RD_LATENCY must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_ram_blk_pipe.sv
// Scoreboard bench for ram_blk_pipe: two instances (latency 1 / read-old and
// latency 2 / write-through) share one stimulus stream.
module tb_ram_blk_pipe;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [3:0]  rd_perr_a, rd_perr_b;
  logic        init_done_a, init_done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  perr;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  ram_blk_pipe #(
    .ADDR_BITS(5), .DATA_BITS(32), .RD_LATENCY(1), .COLLISION_MODE(0)
  ) dut_a (
    .clk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_perr(rd_perr_a),
    .init_done(init_done_a)
  );

  ram_blk_pipe #(
    .ADDR_BITS(5), .DATA_BITS(32), .RD_LATENCY(2), .COLLISION_MODE(1)
  ) dut_b (
    .clk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_perr(rd_perr_b),
    .init_done(init_done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on every rd_valid, flag late/missing strobes by due cycle.
  always @(negedge clk) begin
    if (aresetn) begin
      if (rd_valid_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front();
          chk("a_data", rd_data_a, ea.data);
          chk("a_cycle", 32'(cyc), 32'(ea.due));
          chk("a_perr", {28'd0, rd_perr_a}, {28'd0, ea.perr});
        end
      end else begin
        chk("a_perr_idle", {28'd0, rd_perr_a}, 32'd0);
        if (qa.size() > 0 && cyc > qa[0].due) begin
          ea = qa.pop_front();
          chk("a_missing_valid", 32'(cyc), 32'(ea.due));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (aresetn) begin
      if (rd_valid_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 32'd1, 32'd0);
        end else begin
          eb = qb.pop_front();
          chk("b_data", rd_data_b, eb.data);
          chk("b_cycle", 32'(cyc), 32'(eb.due));
          chk("b_perr", {28'd0, rd_perr_b}, {28'd0, eb.perr});
        end
      end else begin
        chk("b_perr_idle", {28'd0, rd_perr_b}, 32'd0);
        if (qb.size() > 0 && cyc > qb[0].due) begin
          eb = qb.pop_front();
          chk("b_missing_valid", 32'(cyc), 32'(eb.due));
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [4:0] ra,
                       input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic [3:0] exp_perr);
    exp_t e;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    if (re) begin
      e.data = exp_a; e.perr = exp_perr; e.due = cyc + 1;
      qa.push_back(e);
      e.data = exp_b; e.due = cyc + 2;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_data_a"}, rd_data_a, 32'd0);
    chk({tag, "_rd_valid_a"}, {31'd0, rd_valid_a}, 32'd0);
    chk({tag, "_rd_perr_a"}, {28'd0, rd_perr_a}, 32'd0);
    chk({tag, "_init_done_a"}, {31'd0, init_done_a}, 32'd0);
    chk({tag, "_rd_data_b"}, rd_data_b, 32'd0);
    chk({tag, "_rd_valid_b"}, {31'd0, rd_valid_b}, 32'd0);
    chk({tag, "_rd_perr_b"}, {28'd0, rd_perr_b}, 32'd0);
    chk({tag, "_init_done_b"}, {31'd0, init_done_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;

    n = 0;
    while (!init_done_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_cycles_a", 32'(n), 32'd32);
    chk("init_done_b", {31'd0, init_done_b}, 32'd1);

    for (int a = 0; a < 32; a++) issue(1'b0, '0, '0, '0, 1'b1, 5'(a), 32'h0, 32'h0, 4'h0);
    drain();

    issue(1'b1, 5'd3, 32'hAABBCCDD, 4'hF, 1'b0, '0, '0, '0, '0);
    issue(1'b1, 5'd3, 32'h11223344, 4'b0101, 1'b0, '0, '0, '0, '0);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 4'h0);

    issue(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, '0, '0, '0, '0);
    issue(1'b1, 5'd7, 32'hFFFFFFFF, 4'h3, 1'b1, 5'd7, 32'h12345678, 32'h1234FFFF, 4'h0);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd7, 32'h1234FFFF, 32'h1234FFFF, 4'h0);

    issue(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b1, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 4'h0);
    issue(1'b1, 5'd3, 32'h00000000, 4'h0, 1'b1, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 4'h0);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 4'h0);

    issue(1'b0, '0, '0, '0, 1'b1, 5'd0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd1, 32'h0, 32'h0, 4'h0);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd2, 32'h0, 32'h0, 4'h0);
    drain();

`ifdef RAM_BLK_PARITY_EN
    dut_a.par_mem[5][1] = ~dut_a.par_mem[5][1];
    dut_b.par_mem[5][1] = ~dut_b.par_mem[5][1];
    issue(1'b0, '0, '0, '0, 1'b1, 5'd5, 32'h0, 32'h0, 4'b0010);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd4, 32'h0, 32'h0, 4'b0000);
`else
    issue(1'b0, '0, '0, '0, 1'b1, 5'd5, 32'h0, 32'h0, 4'b0000);
    issue(1'b0, '0, '0, '0, 1'b1, 5'd4, 32'h0, 32'h0, 4'b0000);
`endif
    drain();

    // Reset while reads are still in flight in both pipelines.
    rd_en = 1'b1;
    rd_addr = 5'd3;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("pre_reset_valid_a", {31'd0, rd_valid_a}, 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    aresetn = 1'b1;

    n = 0;
    while (!init_done_a && n < 100) begin
      wr_en   = (n < 20);
      wr_addr = 5'(n + 29);
      wr_data = 32'hDEADBEEF;
      wr_be   = 4'hF;
      rd_en   = (n < 20);
      rd_addr = 5'(n);
      @(posedge clk);
      #1;
      n++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("reinit_cycles_a", 32'(n), 32'd32);
    chk("reinit_done_b", {31'd0, init_done_b}, 32'd1);

    for (int a = 0; a < 32; a++) issue(1'b0, '0, '0, '0, 1'b1, 5'(a), 32'h0, 32'h0, 4'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_blk_pipe.md
Name: ram_blk_pipe

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, one clock.
- Successor to the unregistered-read RAM used by the lookup/action tables.
- Adds per-byte write enables, a registered read pipeline of configurable latency with a valid strobe, and defined read/write collision behaviour.
- Adds a post-reset zero-initialisation sequencer, so table contents are deterministic before the control path programs them.

Parameters:
- ADDR_BITS, 5, address width; depth = 2**ADDR_BITS entries.
- DATA_BITS, 32, word width; must be a multiple of 8.
- RD_LATENCY, 1, read latency in cycles from rd_en to rd_valid; legal values are 1 or 2.
- COLLISION_MODE, 0, same-address read and write in the same cycle: 0 = return old data, 1 = write-through (return new bytes).

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_BITS  write data.
- wr_be  in  DATA_BITS/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  DATA_BITS  read data, valid when rd_valid=1.
- rd_valid  out  1  read data strobe.
- rd_perr  out  DATA_BITS/8  per-byte parity error, aligned with rd_data.
- init_done  out  1  high once zero-initialisation has completed.

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, rd_perr=0, init_done=0, FSM enters INIT, init counter=0. Reads in flight are discarded. Memory array itself is not reset.
- FSM states:
  - INIT: writes all-zero words (all bytes enabled, correct parity) to address = counter, one per cycle; counter increments each cycle.
  - At counter = DEPTH-1 the last write occurs and the FSM moves to RUN next cycle; init_done rises on that edge.
  - INIT therefore takes exactly DEPTH cycles after aresetn deasserts.
  - RUN: terminal until the next reset.
- During INIT: wr_en and rd_en are ignored. No memory update from the user port; rd_valid stays 0.
- Write (RUN): on a clk edge with wr_en=1, byte i of mem[wr_addr] is updated only where wr_be[i]=1. wr_be=0 with wr_en=1 is a legal no-op.
- Read (RUN):
  - rd_en=1 samples rd_addr at edge T.
  - RD_LATENCY=1: rd_data/rd_valid present after edge T, i.e. one cycle later.
  - RD_LATENCY=2: one extra register stage; valid after edge T+1.
- Read pipeline is fully pipelined: a new read is accepted every cycle, and rd_valid follows rd_en delayed by RD_LATENCY.
- rd_data holds its last value when rd_valid=0.
- Collision (same address, wr_en and rd_en on the same edge):
  - COLLISION_MODE=0: returns pre-write contents.
  - COLLISION_MODE=1: returns enabled bytes from wr_data and unenabled bytes from the old contents.
- Different-address simultaneous read and write: independent; no stall.
- Address wrap: none. All ADDR_BITS values are valid entries.
- Illegal RD_LATENCY: elaboration-time error via a generate-time check.

Optional Feature:
- Macro RAM_BLK_PARITY_EN.
- Defined:
  - Each byte lane stores one extra even-parity bit, computed on write and on init writes.
  - On read, parity is recomputed; rd_perr[i]=1 for each lane whose stored parity mismatches, aligned with rd_valid.
  - rd_perr is 0 whenever rd_valid=0.
- Undefined: no parity storage; rd_perr is tied to 0.

Decomposition:
- Package ram_blk_pkg:
  - FSM state encoding (ST_INIT, ST_RUN).
  - Collision mode constants (COLL_READ_OLD=0, COLL_WRITE_THRU=1).
  - Function for byte-lane count and per-byte parity.
- Sub-module ram_blk_init_fsm: INIT/RUN state and address counter. Outputs the internal write mux controls (init_we, init_addr) and init_done.
- Array, byte-enable merge, collision bypass and read pipeline stay in the top.

Test Plan:
- Reset then idle: release aresetn. init_done rises exactly 32 cycles later (ADDR_BITS=5). A read of every address returns 0x00000000 with rd_valid one cycle after rd_en.
- Byte enables: write 0xAABBCCDD to addr 3 with wr_be=4'hF, then 0x11223344 with wr_be=4'b0101. Read addr 3 returns 0xAA22CC44.
- Collision: mem[7]=0x12345678; same-edge write 0xFFFFFFFF (wr_be=4'h3) and read of addr 7. COLLISION_MODE=0 returns 0x12345678; COLLISION_MODE=1 returns 0x1234FFFF.
- Pipelining: RD_LATENCY=2, back-to-back reads of addrs 0,1,2 over 3 cycles. rd_valid is high for 3 consecutive cycles starting 2 cycles after the first rd_en, with data in order.
- Reset mid-operation: assert aresetn low while rd_valid is pending. rd_valid=0 immediately. Writes during re-INIT are ignored, and all entries read 0 after init_done.
- Parity (macro defined): force a stored parity bit of lane 1 at addr 5, then read addr 5. rd_perr=4'b0010 with rd_valid; other reads give rd_perr=0.
